// File: rtl/light_phase_ctrl.sv
// Two-road intersection phase controller: one-second prescaler, G/Y/R sequencing with one-hot
// load pulses to the phase down-counter, lamp decode and a flashing-yellow maintenance mode.
module light_phase_ctrl #(
  parameter int unsigned pCLK_DIV           = 50_000_000,
  parameter int unsigned pDIV_WIDTH         = 26,
  parameter int unsigned pTIME_YELLOW_LIGHT = 3,
  parameter int unsigned pCNT_WIDTH         = 5,
  parameter int unsigned pINIT_WIDTH        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   last,
  input  logic [pCNT_WIDTH-1:0]  cnt_in,
  output logic [pINIT_WIDTH-1:0] init,
  output logic                   cnt_en,
  output logic [2:0]             light_main,
  output logic [2:0]             light_side,
  output logic [1:0]             state_out
);

  localparam logic [pDIV_WIDTH-1:0]  DivMax     = pDIV_WIDTH'(pCLK_DIV - 1);
  localparam logic [pCNT_WIDTH-1:0]  YellowTime = pCNT_WIDTH'(pTIME_YELLOW_LIGHT);
  localparam logic [pINIT_WIDTH-1:0] InitGreen  = pINIT_WIDTH'(1);
  localparam logic [pINIT_WIDTH-1:0] InitYellow = pINIT_WIDTH'(2);
  localparam logic [pINIT_WIDTH-1:0] InitRed    = pINIT_WIDTH'(4);

  localparam logic [2:0] LampG = 3'b001;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampR = 3'b100;

  typedef enum logic [1:0] {
    StMainGreen  = 2'd0,
    StMainYellow = 2'd1,
    StMainRed    = 2'd2,
    StFlash      = 2'd3
  } state_e;

  state_e                   state_q;
  logic [pDIV_WIDTH-1:0]    presc_q;
  logic                     blink_q;
  logic [pINIT_WIDTH-1:0]   init_q;
  logic                     tick;

  assign tick = (presc_q == DivMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StMainYellow;
      presc_q <= '0;
      blink_q <= 1'b0;
      init_q  <= '0;
    end else begin
      init_q <= '0;
      if (!run) begin
        state_q <= StFlash;
        presc_q <= tick ? '0 : presc_q + 1'b1;
        // Blink only advances once already flashing, so it starts dark on entry.
        blink_q <= (state_q == StFlash) ? (blink_q ^ tick) : 1'b0;
      end else if (state_q == StFlash) begin
        // Resume through yellow with a fresh tick period.
        state_q <= StMainYellow;
        init_q  <= InitYellow;
        presc_q <= '0;
        blink_q <= 1'b0;
      end else begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        blink_q <= 1'b0;
        if (tick && last) begin
          case (state_q)
            StMainGreen: begin
              state_q <= StMainYellow;
              init_q  <= InitYellow;
            end
            StMainYellow: begin
              state_q <= StMainRed;
              init_q  <= InitRed;
            end
            StMainRed: begin
              state_q <= StMainGreen;
              init_q  <= InitGreen;
            end
            default: state_q <= StFlash;
          endcase
        end
      end
    end
  end

  assign init      = init_q;
  assign state_out = state_q;
  assign cnt_en    = tick & run & (state_q != StFlash) & ~|init_q;

  always_comb begin
    light_main = '0;
    light_side = '0;
    unique case (state_q)
      StMainGreen: begin
        light_main = LampG;
        light_side = LampR;
      end
      StMainYellow: begin
        light_main = LampY;
        light_side = LampR;
      end
      StMainRed: begin
        light_main = LampR;
        // While the load pulse is out the counter still shows the previous phase's 0.
        if (|init_q)                    light_side = LampR;
        else if (cnt_in <= YellowTime)  light_side = LampY;
        else                            light_side = LampG;
      end
      StFlash: begin
        light_main = {1'b0, blink_q, 1'b0};
        light_side = {1'b0, blink_q, 1'b0};
      end
      default: begin
        light_main = '0;
        light_side = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_light_phase_ctrl.sv
// Bench for light_phase_ctrl with pCLK_DIV=4 and a behavioural phase counter (G=15, Y=3, R=18).
// Expected init pulses are queued by the stimulus and checked by an independent monitor.
module tb_light_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b1;
  logic       last;
  logic [4:0] cnt_in;
  logic [2:0] init;
  logic       cnt_en;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [4:0] cnt_q;

  typedef struct {
    int         cyc;
    logic [2:0] init;
    logic [1:0] st;
  } pulse_t;

  pulse_t exp_q[$];

  light_phase_ctrl #(
    .pCLK_DIV           (4),
    .pDIV_WIDTH         (2),
    .pTIME_YELLOW_LIGHT (3),
    .pCNT_WIDTH         (5),
    .pINIT_WIDTH        (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .last       (last),
    .cnt_in     (cnt_in),
    .init       (init),
    .cnt_en     (cnt_en),
    .light_main (light_main),
    .light_side (light_side),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Environment: the phase down-counter the controller drives.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt_q <= 5'd3;
    else if (init[0])         cnt_q <= 5'd15;
    else if (init[1])         cnt_q <= 5'd3;
    else if (init[2])         cnt_q <= 5'd18;
    else if (cnt_en && cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
  end
  assign cnt_in = cnt_q;
  assign last   = (cnt_q == 5'd0);

  // Edge count since reset release; at the negedge after edge k, cyc == k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] i, input logic [1:0] s);
    pulse_t p;
    p.cyc  = c;
    p.init = i;
    p.st   = s;
    exp_q.push_back(p);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_out), 32'd1);
    check({tag, "_main"},  32'(light_main), 32'b010);
    check({tag, "_side"},  32'(light_side), 32'b100);
    check({tag, "_init"},  32'(init), 32'd0);
    check({tag, "_cnten"}, 32'(cnt_en), 32'd0);
  endtask

  // Monitor: every nonzero init must match the next queued pulse and last exactly one clk.
  logic [2:0] prev_init = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_init = '0;
      end else begin
        if (prev_init != 3'd0) check("init_width", 32'(init), 32'd0);
        if (init != 3'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_init at cyc %0d: got %0h expected none", cyc, init);
          end else begin
            pulse_t p;
            p = exp_q.pop_front();
            check("pulse_cyc",   32'(cyc), 32'(p.cyc));
            check("pulse_init",  32'(init), 32'(p.init));
            check("pulse_state", 32'(state_out), 32'(p.st));
          end
        end
        prev_init = init;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout at cyc %0d: got no finish expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    push(16,  3'b100, 2'd2);
    push(92,  3'b001, 2'd0);
    push(156, 3'b010, 2'd1);
    push(172, 3'b100, 2'd2);
    push(248, 3'b001, 2'd0);
    rst_n = 1'b1;

    wait_cyc(2);   check("cnten_pre",   32'(cnt_en), 32'd0);
                   check("main_y0",     32'(light_main), 32'b010);
    wait_cyc(3);   check("cnten_first", 32'(cnt_en), 32'd1);
    wait_cyc(13);  check("last_no_tick", 32'(state_out), 32'd1);
    wait_cyc(16);  check("side_mask",   32'(light_side), 32'b100);
                   check("main_red",    32'(light_main), 32'b100);
    wait_cyc(17);  check("side_green",  32'(light_side), 32'b001);
    wait_cyc(75);  check("side_green_end", 32'(light_side), 32'b001);
    wait_cyc(76);  check("side_yellow", 32'(light_side), 32'b010);
    wait_cyc(92);  check("main_green",  32'(light_main), 32'b001);
                   check("side_red_g",  32'(light_side), 32'b100);
    wait_cyc(160); check("main_yellow", 32'(light_main), 32'b010);

    wait_cyc(270); run = 1'b0;
    wait_cyc(271); check("flash_state", 32'(state_out), 32'd3);
                   check("flash_main0", 32'(light_main), 32'b000);
                   check("flash_init",  32'(init), 32'd0);
    wait_cyc(272); check("flash_main1", 32'(light_main), 32'b010);
                   check("flash_side1", 32'(light_side), 32'b010);
    wait_cyc(275); check("flash_cnten", 32'(cnt_en), 32'd0);
    wait_cyc(276); check("flash_main2", 32'(light_main), 32'b000);
    wait_cyc(280); check("flash_main3", 32'(light_main), 32'b010);

    push(290, 3'b010, 2'd1);
    push(306, 3'b100, 2'd2);
    wait_cyc(289); run = 1'b1;
    wait_cyc(290); check("exit_main",   32'(light_main), 32'b010);
                   check("exit_side",   32'(light_side), 32'b100);
    wait_cyc(292); check("exit_cnten0", 32'(cnt_en), 32'd0);
    wait_cyc(293); check("exit_cnten1", 32'(cnt_en), 32'd1);
    wait_cyc(306); check("red_again",   32'(state_out), 32'd2);

    #1 rst_n = 1'b0;
    #1 check_reset_vals("async");
    push(16, 3'b100, 2'd2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);  check("r2_cnten_pre", 32'(cnt_en), 32'd0);
    wait_cyc(3);  check("r2_cnten",     32'(cnt_en), 32'd1);
    wait_cyc(16); check("r2_side_mask", 32'(light_side), 32'b100);
    wait_cyc(20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
